// File: rtl/picorv32_wb_bridge.sv
// ---------------------------------------------------------------------------------------------
// picorv32_wb_bridge
//
// Registered bridge from the PicoRV32 native memory port to a Wishbone B4 master.
// Supports classic and pipelined Wishbone. Also reports bus errors, and aborts any
// transfer that gets no ack/err within TIMEOUT_CYCLES bus cycles, so that a dead slave
// cannot hang the core.
//
// Parameters
//   ADDR_WIDTH      address width of mem_addr / wb_adr_o
//   DATA_WIDTH      data width; byte-select width is DATA_WIDTH/8
//   PIPELINED       0: classic (stb held until termination)
//                   1: pipelined (stb held only until accepted, honours wb_stall_i)
//   TIMEOUT_CYCLES  bus cycles to wait for ack/err before aborting; 0 disables
//
// Ports
//   sys_clk, rst_n        clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb   core request (wstrb == 0 means read)
//   mem_rdata, mem_ready  read data and one-cycle completion pulse back to the core
//   wb_cyc_o .. wb_dat_o  Wishbone master outputs (all registered)
//   wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i   Wishbone slave responses
//   err_clr_i             clears the sticky error flag
//   bus_error_o           sticky: a bus error or timeout has occurred
//   err_addr_o            address of the most recent failed transfer
//
// Timing with a zero-wait slave: the request is registered on the edge where mem_valid is
// seen, stb is high for one cycle, the ack is sampled on the next edge, and mem_ready is
// high for the following cycle. The bridge is back in IDLE one cycle later, which gives
// 3 cycles per access.
// ---------------------------------------------------------------------------------------------
module picorv32_wb_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PIPELINED      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    // core side
    input  logic                    mem_valid,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_ready,
    // wishbone master
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_stall_i,
    // error reporting
    input  logic                    err_clr_i,
    output logic                    bus_error_o,
    output logic [ADDR_WIDTH-1:0]   err_addr_o
);

    localparam int unsigned SelW = DATA_WIDTH / 8;

    // Wide enough to hold TIMEOUT_CYCLES-1, and never zero bits wide.
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CntW-1:0] CntLast =
        CntW'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);
    localparam logic [CntW-1:0] CntOne = CntW'(32'd1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic [SelW-1:0]         sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    berr_q, berr_d;
    logic [ADDR_WIDTH-1:0]   eaddr_q, eaddr_d;

    logic                    timeout_hit;
    logic                    finish;
    logic                    fail;
    logic                    req_we;

    // The counter holds the number of bus cycles already completed without a response,
    // so it equals TIMEOUT_CYCLES-1 during the last permitted cycle.
    assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cnt_q == CntLast);
    assign req_we      = |mem_wstrb;

    // -----------------------------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            berr_q  <= 1'b0;
            eaddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            berr_q  <= berr_d;
            eaddr_q <= eaddr_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        // A clear request is applied first so that an error in the same cycle overrides it.
        berr_d  = berr_q & ~err_clr_i;
        eaddr_d = eaddr_q;
        finish  = 1'b0;
        fail    = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (mem_valid) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = req_we;
                    sel_d   = req_we ? mem_wstrb : {SelW{1'b1}};
                    adr_d   = mem_addr;
                    dat_d   = mem_wdata;
                    state_d = StReq;
                end
            end

            StReq, StWait: begin
                // Priority: err over ack, ack over an expiring timeout.
                if (wb_err_i) begin
                    finish = 1'b1;
                    fail   = 1'b1;
                end else if (wb_ack_i) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    finish = 1'b1;
                    fail   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    if (state_q == StReq) begin
                        if (PIPELINED == 32'd0) begin
                            // Classic mode keeps stb asserted until termination.
                            state_d = StWait;
                        end else if (!wb_stall_i) begin
                            // Request accepted by the slave; only cyc stays up.
                            stb_d   = 1'b0;
                            state_d = StWait;
                        end
                    end
                end

                if (finish) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    ready_d = 1'b1;
                    rdata_d = (fail || we_q) ? '0 : wb_dat_i;
                    if (fail) begin
                        berr_d  = 1'b1;
                        eaddr_d = adr_q;
                    end
                end
            end

            StDone: begin
                // Responses arriving here are stray and deliberately ignored.
                cnt_d   = '0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign mem_rdata   = rdata_q;
    assign mem_ready   = ready_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign bus_error_o = berr_q;
    assign err_addr_o  = eaddr_q;

    // -----------------------------------------------------------------------------------------
    // Protocol invariants
    // -----------------------------------------------------------------------------------------
    a_stb_in_cyc: assert property (@(posedge sys_clk) disable iff (!rst_n)
        wb_stb_o |-> wb_cyc_o);

    a_ready_pulse: assert property (@(posedge sys_clk) disable iff (!rst_n)
        mem_ready |=> !mem_ready);

    a_ready_outside_cyc: assert property (@(posedge sys_clk) disable iff (!rst_n)
        mem_ready |-> !wb_cyc_o);

    a_classic_stb: assert property (@(posedge sys_clk) disable iff (!rst_n)
        (PIPELINED == 32'd0 && wb_cyc_o) |-> wb_stb_o);

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
module tb_picorv32_wb_bridge;

    localparam int T = 8;
    localparam int KAck  = 0;
    localparam int KErr  = 1;
    localparam int KBoth = 2;
    localparam int KNone = 3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          kind;
        int          k;
        int          s;
        logic [31:0] sdat;
        int          clr_at;
        logic [31:0] exp_rdata;
        int          exp_n;
        int          exp_stb_p;
        logic        exp_berr;
        logic [31:0] exp_eaddr;
    } vec_t;

    logic        sys_clk;
    logic        rst_n;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_stall_i;
    logic        err_clr_i;

    logic [31:0] o_rdata [2];
    logic        o_ready [2];
    logic        o_cyc   [2];
    logic        o_stb   [2];
    logic        o_we    [2];
    logic [3:0]  o_sel   [2];
    logic [31:0] o_adr   [2];
    logic [31:0] o_dat   [2];
    logic        o_berr  [2];
    logic [31:0] o_eaddr [2];

    int checks;
    int errors;
    int txn_id;
    logic        m_berr;
    logic [31:0] m_eaddr;
    vec_t tab [10];

    picorv32_wb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .PIPELINED      (0),
        .TIMEOUT_CYCLES (T)
    ) u_dut_c (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (o_rdata[0]),
        .mem_ready   (o_ready[0]),
        .wb_cyc_o    (o_cyc[0]),
        .wb_stb_o    (o_stb[0]),
        .wb_we_o     (o_we[0]),
        .wb_sel_o    (o_sel[0]),
        .wb_adr_o    (o_adr[0]),
        .wb_dat_o    (o_dat[0]),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .wb_stall_i  (wb_stall_i),
        .err_clr_i   (err_clr_i),
        .bus_error_o (o_berr[0]),
        .err_addr_o  (o_eaddr[0])
    );

    picorv32_wb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .PIPELINED      (1),
        .TIMEOUT_CYCLES (T)
    ) u_dut_p (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (o_rdata[1]),
        .mem_ready   (o_ready[1]),
        .wb_cyc_o    (o_cyc[1]),
        .wb_stb_o    (o_stb[1]),
        .wb_we_o     (o_we[1]),
        .wb_sel_o    (o_sel[1]),
        .wb_adr_o    (o_adr[1]),
        .wb_dat_o    (o_dat[1]),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .wb_stall_i  (wb_stall_i),
        .err_clr_i   (err_clr_i),
        .bus_error_o (o_berr[1]),
        .err_addr_o  (o_eaddr[1])
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn=%0d dut=%0d got=%h expected=%h", name, txn_id, d, act, exp);
        end
    endtask

    function automatic logic any_out(input int d);
        return |{o_rdata[d], o_ready[d], o_cyc[d], o_stb[d], o_we[d], o_sel[d], o_adr[d],
                 o_dat[d], o_berr[d], o_eaddr[d]};
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int kind, input int k,
                                input int s, input logic [31:0] sdat, input int clr_at,
                                input logic [31:0] exp_rdata, input int exp_n,
                                input int exp_stb_p, input logic exp_berr,
                                input logic [31:0] exp_eaddr);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.kind = kind; v.k = k; v.s = s;
        v.sdat = sdat; v.clr_at = clr_at; v.exp_rdata = exp_rdata; v.exp_n = exp_n;
        v.exp_stb_p = exp_stb_p; v.exp_berr = exp_berr; v.exp_eaddr = exp_eaddr;
        return v;
    endfunction

    // Transaction-level reference: the response arrives in bus cycle k unless the
    // timeout (T cycles) comes first; err beats ack, ack beats an expiring timeout.
    function automatic vec_t model(input vec_t v, input logic berr_in,
                                   input logic [31:0] eaddr_in);
        vec_t r;
        int   resp_at;
        bit   is_err;
        r = v;
        resp_at = (v.kind == KNone) ? 1000 : v.k;
        r.exp_n = (resp_at <= T) ? resp_at : T;
        is_err = (resp_at > T) || (v.kind == KErr) || (v.kind == KBoth);
        r.exp_rdata = (!is_err && v.wstrb == 4'h0) ? v.sdat : 32'h0;
        r.exp_stb_p = (v.s + 1 < r.exp_n) ? v.s + 1 : r.exp_n;
        if (is_err) r.exp_berr = 1'b1;
        else if (v.clr_at >= 1 && v.clr_at <= r.exp_n) r.exp_berr = 1'b0;
        else r.exp_berr = berr_in;
        r.exp_eaddr = is_err ? v.addr : eaddr_in;
        return r;
    endfunction

    // Starts at a falling edge with both bridges idle; returns at the falling edge of the
    // first idle cycle after completion, ready for the next request.
    task automatic run_txn(input vec_t v, input bit drop_early, input bit noise);
        int          ncyc [2];
        int          nstb [2];
        int          nrdy [2];
        int          rdy_at [2];
        bit          attr_bad [2];
        logic [31:0] rd_at_rdy [2];
        logic        exp_we;
        logic [3:0]  exp_sel;
        int          t;
        bit          done;
        exp_we  = |v.wstrb;
        exp_sel = exp_we ? v.wstrb : 4'hF;
        for (int d = 0; d < 2; d++) begin
            ncyc[d] = 0; nstb[d] = 0; nrdy[d] = 0; rdy_at[d] = 0;
            attr_bad[d] = 1'b0; rd_at_rdy[d] = 32'h0;
        end
        mem_valid = 1'b1; mem_addr = v.addr; mem_wdata = v.wdata; mem_wstrb = v.wstrb;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; err_clr_i = 1'b0;
        t = 0;
        done = 1'b0;
        while (!done && t < 40) begin
            @(negedge sys_clk);
            t++;
            for (int d = 0; d < 2; d++) begin
                if (o_cyc[d]) begin
                    ncyc[d]++;
                    if (o_stb[d]) nstb[d]++;
                    if (o_we[d] !== exp_we || o_sel[d] !== exp_sel || o_adr[d] !== v.addr ||
                        o_dat[d] !== v.wdata) attr_bad[d] = 1'b1;
                end else if (o_stb[d]) begin
                    attr_bad[d] = 1'b1;
                end
                if (o_ready[d]) begin
                    nrdy[d]++;
                    rdy_at[d] = t;
                    rd_at_rdy[d] = o_rdata[d];
                end
            end
            if (drop_early || o_ready[0]) mem_valid = 1'b0;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; err_clr_i = 1'b0;
            wb_dat_i = $urandom;
            if (o_cyc[0]) begin
                wb_ack_i   = (v.kind == KAck || v.kind == KBoth) && (t == v.k);
                wb_err_i   = (v.kind == KErr || v.kind == KBoth) && (t == v.k);
                wb_stall_i = (t <= v.s);
                err_clr_i  = (t == v.clr_at);
                if (t == v.k) wb_dat_i = v.sdat;
            end else if (noise && o_ready[0]) begin
                wb_ack_i = 1'($urandom);
                wb_err_i = 1'($urandom);
            end
            if (nrdy[0] > 0 && t > rdy_at[0]) done = 1'b1;
        end
        check("access_cycles", 0, 32'(t), 32'(v.exp_n + 2));
        for (int d = 0; d < 2; d++) begin
            check("ready_pulses", d, 32'(nrdy[d]), 32'd1);
            check("ready_cycle", d, 32'(rdy_at[d]), 32'(v.exp_n + 1));
            check("cyc_cycles", d, 32'(ncyc[d]), 32'(v.exp_n));
            check("stb_cycles", d, 32'(nstb[d]), 32'((d == 0) ? v.exp_n : v.exp_stb_p));
            check("bus_attrs", d, 32'(attr_bad[d]), 32'd0);
            check("rdata", d, rd_at_rdy[d], v.exp_rdata);
            check("rdata_hold", d, o_rdata[d], v.exp_rdata);
            check("bus_error", d, 32'(o_berr[d]), 32'(v.exp_berr));
            check("err_addr", d, o_eaddr[d], v.exp_eaddr);
        end
        m_berr  = v.exp_berr;
        m_eaddr = v.exp_eaddr;
        txn_id++;
    endtask

    initial begin
        vec_t v;
        bit   seen;
        checks = 0; errors = 0; txn_id = 0;
        m_berr = 1'b0; m_eaddr = 32'h0;
        rst_n = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        mem_wstrb = 4'h0; wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        wb_stall_i = 1'b0; err_clr_i = 1'b0;

        //          addr          wdata         strb  kind   k  s  sdat          clr
        //          exp_rdata     n  stb_p berr eaddr
        tab[0] = mk(32'h100, 32'h0, 4'h0, KAck, 3, 0, 32'hCAFEBABE, 0,
                    32'hCAFEBABE, 3, 1, 1'b0, 32'h0);
        tab[1] = mk(32'h204, 32'h00AB0000, 4'h4, KAck, 1, 0, 32'h12345678, 0,
                    32'h0, 1, 1, 1'b0, 32'h0);
        tab[2] = mk(32'h208, 32'h0, 4'h0, KAck, 5, 3, 32'h5A5A0001, 0,
                    32'h5A5A0001, 5, 4, 1'b0, 32'h0);
        tab[3] = mk(32'h300, 32'h0, 4'h0, KErr, 2, 0, 32'hFFFFFFFF, 0,
                    32'h0, 2, 1, 1'b1, 32'h300);
        tab[4] = mk(32'h400, 32'h0, 4'h0, KNone, 0, 0, 32'h77777777, 0,
                    32'h0, 8, 1, 1'b1, 32'h400);
        tab[5] = mk(32'h404, 32'hDEADBEEF, 4'hF, KBoth, 1, 0, 32'h55555555, 0,
                    32'h0, 1, 1, 1'b1, 32'h404);
        tab[6] = mk(32'h408, 32'h0, 4'h0, KAck, 8, 0, 32'h0BADF00D, 1,
                    32'h0BADF00D, 8, 1, 1'b0, 32'h404);
        tab[7] = mk(32'h40C, 32'h0, 4'h0, KErr, 3, 0, 32'h99999999, 3,
                    32'h0, 3, 1, 1'b1, 32'h40C);
        tab[8] = mk(32'h500, 32'h0, 4'h0, KAck, 2, 5, 32'h11112222, 1,
                    32'h11112222, 2, 2, 1'b0, 32'h40C);
        tab[9] = mk(32'h504, 32'h0, 4'h0, KNone, 0, 10, 32'h0, 0,
                    32'h0, 8, 8, 1'b1, 32'h504);

        repeat (2) @(negedge sys_clk);
        for (int d = 0; d < 2; d++) check("reset_state", d, 32'(any_out(d)), 32'd0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        for (int d = 0; d < 2; d++) check("idle_after_reset", d, 32'(any_out(d)), 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                err_clr_i = 1'b1;
                @(negedge sys_clk);
                err_clr_i = 1'b0;
                for (int d = 0; d < 2; d++) begin
                    check("err_clr", d, 32'(o_berr[d]), 32'd0);
                    check("err_addr_kept", d, o_eaddr[d], 32'h300);
                end
            end
            run_txn(tab[i], 1'b0, 1'b0);
        end

        // Reset in the middle of a bus cycle, then stray responses while idle.
        mem_valid = 1'b1; mem_addr = 32'h600; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        repeat (3) @(negedge sys_clk);
        mem_valid = 1'b0;
        for (int d = 0; d < 2; d++) check("cyc_before_reset", d, 32'(o_cyc[d]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check("reset_async", d, 32'(any_out(d)), 32'd0);
        @(negedge sys_clk);
        for (int d = 0; d < 2; d++) check("reset_held", d, 32'(any_out(d)), 32'd0);
        rst_n = 1'b1;
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hFFFFFFFF;
        seen = 1'b0;
        repeat (3) begin
            @(negedge sys_clk);
            for (int d = 0; d < 2; d++) seen = seen | o_ready[d] | o_cyc[d];
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        check("stray_resp_activity", 0, 32'(seen), 32'd0);
        for (int d = 0; d < 2; d++) check("stray_resp_idle", d, 32'(any_out(d)), 32'd0);
        m_berr = 1'b0; m_eaddr = 32'h0;

        // Back-to-back zero-wait reads.
        for (int i = 0; i < 10; i++) begin
            v = mk(32'h1000 + 32'(4 * i), 32'h0, 4'h0, KAck, 1, 0, $urandom, 0,
                   32'h0, 0, 0, 1'b0, 32'h0);
            v = model(v, m_berr, m_eaddr);
            run_txn(v, 1'b0, 1'b0);
        end

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            v.addr   = $urandom & 32'hFFFF_FFFC;
            v.wdata  = $urandom;
            v.wstrb  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            v.kind   = int'($urandom_range(0, 3));
            v.k      = int'($urandom_range(1, 10));
            v.s      = int'($urandom_range(0, 4));
            v.sdat   = $urandom;
            v.clr_at = int'($urandom_range(0, 6));
            v = model(v, m_berr, m_eaddr);
            run_txn(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
